waveform_gen: RTL

WAVEFORM_GEN -- requirements
Module: waveform_gen

---
 rtl/waveform_pkg.sv | 28 ++
 rtl/sine_quarter_rom.sv | 53 +++++
 rtl/waveform_gen.sv | 117 +++++++++++
 3 files changed

// File: rtl/waveform_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : waveform_pkg
//  Description : Shared shape encodings, widths and helpers for waveform_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
package waveform_pkg;

    localparam int PHASE_W  = 8;
    localparam int SAMPLE_W = 8;
    localparam int BASE_DIV = 16;
    localparam int PRESC_W  = 11;
    localparam int FR_W     = 3;

    typedef enum logic [1:0] {
        SHAPE_SQUARE = 2'b00,
        SHAPE_SAW    = 2'b01,
        SHAPE_TRI    = 2'b10,
        SHAPE_SINE   = 2'b11
    } shape_e;

    // Terminal prescaler count for a given rate select: (16 << fr) - 1.
    function automatic logic [PRESC_W-1:0] period_last(input logic [FR_W-1:0] fr);
        return PRESC_W'((BASE_DIV << fr) - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sine_quarter_rom.sv
`default_nettype none
// ============================================================================
//  Module      : sine_quarter_rom
//  Description : First-quarter sine table, round(127.5+127.5*sin(2pi(i+.5)/256)).
//  Revision    : 1.0 - initial release
// ============================================================================
module sine_quarter_rom (
    input  logic [5:0] addr_i,
    output logic [7:0] data_o
);

    // Pure lookup; the half-sample offset makes the quarter mirror exactly.
    always_comb begin
        data_o = 8'd0;
        case (addr_i)
            6'd0:  data_o = 8'd129;  6'd1:  data_o = 8'd132;
            6'd2:  data_o = 8'd135;  6'd3:  data_o = 8'd138;
            6'd4:  data_o = 8'd142;  6'd5:  data_o = 8'd145;
            6'd6:  data_o = 8'd148;  6'd7:  data_o = 8'd151;
            6'd8:  data_o = 8'd154;  6'd9:  data_o = 8'd157;
            6'd10: data_o = 8'd160;  6'd11: data_o = 8'd163;
            6'd12: data_o = 8'd166;  6'd13: data_o = 8'd169;
            6'd14: data_o = 8'd172;  6'd15: data_o = 8'd175;
            6'd16: data_o = 8'd178;  6'd17: data_o = 8'd181;
            6'd18: data_o = 8'd183;  6'd19: data_o = 8'd186;
            6'd20: data_o = 8'd189;  6'd21: data_o = 8'd192;
            6'd22: data_o = 8'd194;  6'd23: data_o = 8'd197;
            6'd24: data_o = 8'd200;  6'd25: data_o = 8'd202;
            6'd26: data_o = 8'd205;  6'd27: data_o = 8'd207;
            6'd28: data_o = 8'd210;  6'd29: data_o = 8'd212;
            6'd30: data_o = 8'd214;  6'd31: data_o = 8'd217;
            6'd32: data_o = 8'd219;  6'd33: data_o = 8'd221;
            6'd34: data_o = 8'd223;  6'd35: data_o = 8'd225;
            6'd36: data_o = 8'd227;  6'd37: data_o = 8'd229;
            6'd38: data_o = 8'd231;  6'd39: data_o = 8'd233;
            6'd40: data_o = 8'd234;  6'd41: data_o = 8'd236;
            6'd42: data_o = 8'd238;  6'd43: data_o = 8'd239;
            6'd44: data_o = 8'd241;  6'd45: data_o = 8'd242;
            6'd46: data_o = 8'd243;  6'd47: data_o = 8'd245;
            6'd48: data_o = 8'd246;  6'd49: data_o = 8'd247;
            6'd50: data_o = 8'd248;  6'd51: data_o = 8'd249;
            6'd52: data_o = 8'd250;  6'd53: data_o = 8'd251;
            6'd54: data_o = 8'd252;  6'd55: data_o = 8'd252;
            6'd56: data_o = 8'd253;  6'd57: data_o = 8'd253;
            6'd58: data_o = 8'd254;  6'd59: data_o = 8'd254;
            6'd60: data_o = 8'd255;  6'd61: data_o = 8'd255;
            6'd62: data_o = 8'd255;  6'd63: data_o = 8'd255;
            default: data_o = 8'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/waveform_gen.sv
`default_nettype none
// ============================================================================
//  Module      : waveform_gen
//  Description : Prescaled phase accumulator driving square/saw/tri/sine
//                samples through a valid/ready handshake with sticky overrun.
//  Revision    : 1.0 - initial release
// ============================================================================
module waveform_gen
    import waveform_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [1:0]          fsel_i,
    input  logic [FR_W-1:0]     fr_i,
    input  logic                sample_ready_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                sample_valid_o,
    output logic                overrun_o
);

    logic [PRESC_W-1:0]  presc_q,   presc_d;
    logic [FR_W-1:0]     fr_q,      fr_d;
    logic [PHASE_W-1:0]  phase_q,   phase_d;
    logic [SAMPLE_W-1:0] sample_q,  sample_d;
    logic                valid_q,   valid_d;
    logic                overrun_q, overrun_d;

    logic                tick;
    logic                xfer;
    logic [5:0]          rom_addr;
    logic [7:0]          rom_data;
    logic [7:0]          tri_ramp;
    logic [SAMPLE_W-1:0] shape;

    // Odd quarters read the table backwards to mirror the first quarter.
    assign rom_addr = phase_q[6] ? ~phase_q[5:0] : phase_q[5:0];

    sine_quarter_rom u_rom (
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    // Shape of the current phase; only captured on tick cycles.
    always_comb begin
        shape    = '0;
        tri_ramp = {phase_q[6:0], 1'b0};
        case (shape_e'(fsel_i))
            SHAPE_SQUARE: shape = phase_q[7] ? 8'h00 : 8'hFF;
            SHAPE_SAW:    shape = phase_q;
            SHAPE_TRI:    shape = phase_q[7] ? ~tri_ramp : tri_ramp;
            SHAPE_SINE:   shape = phase_q[7] ? (8'd255 - rom_data) : rom_data;
            default:      shape = '0;
        endcase
    end

    // Prescaler, phase advance and sample handshake next-state.
    always_comb begin
        presc_d   = presc_q;
        fr_d      = fr_q;
        phase_d   = phase_q;
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        tick = en_i && (presc_q == period_last(fr_q));
        xfer = valid_q && sample_ready_i;

        // Rate select only takes effect at a wrap so periods are never cut short.
        if (!en_i) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
            fr_d    = fr_i;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        if (tick) begin
            phase_d = phase_q + 1'b1;
            if (!valid_q || xfer) begin
                sample_d = shape;
                valid_d  = 1'b1;
            end else begin
                // Unconsumed sample is kept; the new one is dropped.
                overrun_d = 1'b1;
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q   <= '0;
            fr_q      <= '0;
            phase_q   <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            fr_q      <= fr_d;
            phase_q   <= phase_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign overrun_o      = overrun_q;

endmodule
`default_nettype wire
